// File: rtl/ghost_ctrl_pkg.sv
// Shared types and constants for the ghost sequencer.
// Phase encoding doubles as the external phase code.
package ghost_ctrl_pkg;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_RUN    = 2'd1,
    PH_FRIGHT = 2'd2,
    PH_FREEZE = 2'd3
  } phase_e;

  localparam int MAX_GHOSTS = 4;

  // Taps 16,14,13,11 mapped onto bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] s
  );
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ghost_mode_scheduler_timer.sv
// Per-ghost frame counter, turn pulse and held
// random selector.
module ghost_turn_timer #(
  parameter int PERIOD = 150,
  parameter int OFFSET = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       sof_i,
  input  logic       load_i,
  input  logic [1:0] rnd_i,
  output logic       turn_o,
  output logic [1:0] random_o
);

  localparam int W = $clog2(PERIOD) + 1;
  localparam logic [W-1:0] OFF  = W'(OFFSET);
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         turn_q, turn_d;
  logic [1:0]   rnd_q, rnd_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= OFF;
      turn_q <= 1'b0;
      rnd_q  <= 2'b00;
    end else begin
      cnt_q  <= cnt_d;
      turn_q <= turn_d;
      rnd_q  <= rnd_d;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    turn_d = 1'b0;
    rnd_d  = rnd_q;
    if (load_i) begin
      cnt_d = OFF;
    end else if (en_i && sof_i) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        turn_d = 1'b1;
        rnd_d  = rnd_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign turn_o   = turn_q;
  assign random_o = rnd_q;

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Game-phase sequencer and staggered turn/random
// source for all ghost movers.
module ghost_mode_scheduler
  import ghost_ctrl_pkg::*;
#(
  parameter int          NUM_GHOSTS         = 2,
  parameter int          TURN_PERIOD_FRAMES = 150,
  parameter int          FRIGHT_FRAMES      = 180,
  parameter int          FREEZE_FRAMES      = 60,
  parameter logic [15:0] LFSR_SEED          = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic                    game_start,
  input  logic                    power_pellet,
  input  logic [NUM_GHOSTS-1:0]   collision_pac_ghost,
  output logic [NUM_GHOSTS-1:0]   turn_pulse,
  output logic [2*NUM_GHOSTS-1:0] random,
  output logic                    ghost_stop,
  output logic [NUM_GHOSTS-1:0]   ghost_reset,
  output logic                    frightened,
  output logic                    life_lost,
  output logic                    ghost_eaten,
  output logic [1:0]              phase
);

  localparam int PMAX =
    (FRIGHT_FRAMES > FREEZE_FRAMES) ?
    FRIGHT_FRAMES : FREEZE_FRAMES;
  localparam int PW = $clog2(PMAX) + 1;
  localparam logic [PW-1:0] FR_LAST =
    PW'(FRIGHT_FRAMES - 1);
  localparam logic [PW-1:0] FZ_LAST =
    PW'(FREEZE_FRAMES - 1);
  localparam int STAGGER =
    TURN_PERIOD_FRAMES / NUM_GHOSTS;

  phase_e                  state_q, state_d;
  logic [PW-1:0]           pc_q, pc_d;
  logic [15:0]             lfsr_q;
  logic [NUM_GHOSTS-1:0]   coll_q;
  logic [NUM_GHOSTS-1:0]   rise;
  logic [NUM_GHOSTS-1:0]   grst_q, grst_d;
  logic                    life_q, life_d;
  logic                    eaten_q, eaten_d;
  logic                    reload;
  logic                    run_en;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= PH_IDLE;
      pc_q    <= '0;
      lfsr_q  <= LFSR_SEED;
      coll_q  <= '0;
      grst_q  <= '0;
      life_q  <= 1'b0;
      eaten_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lfsr_q  <= lfsr_step(lfsr_q);
      coll_q  <= collision_pac_ghost;
      grst_q  <= grst_d;
      life_q  <= life_d;
      eaten_q <= eaten_d;
    end
  end

  assign rise = collision_pac_ghost & ~coll_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    grst_d  = '0;
    life_d  = 1'b0;
    eaten_d = 1'b0;
    reload  = 1'b0;
    unique case (state_q)
      PH_IDLE: begin
        if (game_start) begin
          state_d = PH_RUN;
          grst_d  = '1;
          reload  = 1'b1;
        end
      end
      PH_RUN: begin
        // A fatal hit outranks a pellet eaten in the same clock.
        if (|collision_pac_ghost) begin
          state_d = PH_FREEZE;
          life_d  = 1'b1;
          pc_d    = '0;
        end else if (power_pellet) begin
          state_d = PH_FRIGHT;
          pc_d    = '0;
        end
      end
      PH_FRIGHT: begin
        if (|rise) begin
          grst_d  = rise;
          eaten_d = 1'b1;
        end
        if (power_pellet) begin
          pc_d = '0;
        end else if (startOfFrame) begin
          if (pc_q == FR_LAST) begin
            state_d = PH_RUN;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      PH_FREEZE: begin
        if (startOfFrame) begin
          if (pc_q == FZ_LAST) begin
            state_d = PH_RUN;
            grst_d  = '1;
            reload  = 1'b1;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
    endcase
  end

  assign run_en = (state_q == PH_RUN) ||
                  (state_q == PH_FRIGHT);

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_timer
    ghost_turn_timer #(
      .PERIOD (TURN_PERIOD_FRAMES),
      .OFFSET (g * STAGGER)
    ) u_timer (
      .clk_i    (clk),
      .rst_ni   (resetN),
      .en_i     (run_en),
      .sof_i    (startOfFrame),
      .load_i   (reload),
      .rnd_i    (lfsr_q[2*g +: 2]),
      .turn_o   (turn_pulse[g]),
      .random_o (random[2*g +: 2])
    );
  end

  assign ghost_stop  = (state_q == PH_IDLE) ||
                       (state_q == PH_FREEZE);
  assign frightened  = (state_q == PH_FRIGHT);
  assign ghost_reset = grst_q;
  assign life_lost   = life_q;
  assign ghost_eaten = eaten_q;
  assign phase       = state_q;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Scoreboard bench: stimulus queues expected pulse
// events, a negedge monitor pops and compares them.
module tb_ghost_mode_scheduler;

  localparam int NG = 2;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic startOfFrame = 1'b0;
  logic game_start = 1'b0;
  logic power_pellet = 1'b0;
  logic [NG-1:0]   collision_pac_ghost = '0;
  logic [NG-1:0]   turn_pulse;
  logic [2*NG-1:0] random;
  logic            ghost_stop;
  logic [NG-1:0]   ghost_reset;
  logic            frightened;
  logic            life_lost;
  logic            ghost_eaten;
  logic [1:0]      phase;

  int n_cmp = 0;
  int n_bad = 0;
  int frame = 0;

  typedef struct packed {
    logic [1:0]  turn;
    logic [1:0]  grst;
    logic        life;
    logic        eaten;
    logic [1:0]  ph;
    logic        stop;
    logic        fr;
    logic [31:0] frm;
  } ev_t;

  ev_t exp_q[$];

  always #5 clk = ~clk;

  ghost_mode_scheduler #(
    .NUM_GHOSTS         (NG),
    .TURN_PERIOD_FRAMES (150),
    .FRIGHT_FRAMES      (180),
    .FREEZE_FRAMES      (60),
    .LFSR_SEED          (16'hACE1)
  ) dut (
    .clk                 (clk),
    .resetN              (resetN),
    .startOfFrame        (startOfFrame),
    .game_start          (game_start),
    .power_pellet        (power_pellet),
    .collision_pac_ghost (collision_pac_ghost),
    .turn_pulse          (turn_pulse),
    .random              (random),
    .ghost_stop          (ghost_stop),
    .ghost_reset         (ghost_reset),
    .frightened          (frightened),
    .life_lost           (life_lost),
    .ghost_eaten         (ghost_eaten),
    .phase               (phase)
  );

  // Reference LFSR; lfsr_prev is the value the DUT
  // captured on the edge that raised a turn pulse.
  logic [15:0] lfsr_m, lfsr_prev;
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lfsr_m    <= 16'hACE1;
      lfsr_prev <= 16'hACE1;
    end else begin
      lfsr_prev <= lfsr_m;
      lfsr_m    <= {lfsr_m[14:0],
                    lfsr_m[15] ^ lfsr_m[13] ^
                    lfsr_m[12] ^ lfsr_m[10]};
    end
  end

  always @(negedge clk) begin
    ev_t got, e;
    if (resetN && (|turn_pulse || |ghost_reset ||
                   life_lost || ghost_eaten)) begin
      got = '{turn_pulse, ghost_reset, life_lost,
              ghost_eaten, phase, ghost_stop,
              frightened, frame};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse frame=%0d turn=%b grst=%b life=%b eaten=%b",
                 frame, turn_pulse, ghost_reset,
                 life_lost, ghost_eaten);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_bad++;
          $display("FAIL event got turn=%b grst=%b life=%b eaten=%b ph=%0d stop=%b fr=%b frame=%0d need turn=%b grst=%b life=%b eaten=%b ph=%0d stop=%b fr=%b frame=%0d",
                   got.turn, got.grst, got.life, got.eaten,
                   got.ph, got.stop, got.fr, got.frm,
                   e.turn, e.grst, e.life, e.eaten,
                   e.ph, e.stop, e.fr, e.frm);
        end
      end
      for (int i = 0; i < NG; i++) begin
        if (turn_pulse[i]) begin
          n_cmp++;
          if (random[2*i +: 2] !== lfsr_prev[2*i +: 2]) begin
            n_bad++;
            $display("FAIL random%0d frame=%0d got=%b need=%b",
                     i, frame, random[2*i +: 2],
                     lfsr_prev[2*i +: 2]);
          end
        end
      end
    end
  end

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic sof(input int n);
    for (int k = 0; k < n; k++) begin
      startOfFrame = 1'b1;
      frame++;
      clk1();
      startOfFrame = 1'b0;
      clk1();
      clk1();
    end
  endtask

  task automatic push(
    input logic [1:0] turn, input logic [1:0] grst,
    input logic life, input logic eaten,
    input logic [1:0] ph, input logic stop,
    input logic fr, input int frm
  );
    exp_q.push_back('{turn, grst, life, eaten,
                      ph, stop, fr, frm});
  endtask

  task automatic chk(
    input string nm, input logic [31:0] got,
    input logic [31:0] need
  );
    n_cmp++;
    if (got !== need) begin
      n_bad++;
      $display("FAIL %s frame=%0d got=%0h need=%0h",
               nm, frame, got, need);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) clk1();
    chk("rst_phase", phase, 0);
    chk("rst_stop", ghost_stop, 1);
    chk("rst_fright", frightened, 0);
    chk("rst_random", random, 0);
    chk("rst_pulses", {turn_pulse, ghost_reset,
                       life_lost, ghost_eaten}, 0);
    resetN = 1'b1;
    clk1();
    clk1();
    chk("idle_hold", phase, 0);

    push(2'b00, 2'b11, 0, 0, 1, 0, 0, 0);
    game_start = 1'b1;
    clk1();
    game_start = 1'b0;
    clk1();
    chk("run_phase", phase, 1);
    chk("run_stop", ghost_stop, 0);

    push(2'b10, 2'b00, 0, 0, 1, 0, 0, 75);
    push(2'b01, 2'b00, 0, 0, 1, 0, 0, 150);
    sof(150);

    push(2'b00, 2'b00, 1, 0, 3, 1, 0, 150);
    collision_pac_ghost = 2'b01;
    repeat (10) clk1();
    collision_pac_ghost = 2'b00;
    chk("frz_phase", phase, 3);
    sof(30);
    chk("frz_stop_mid", ghost_stop, 1);
    push(2'b00, 2'b11, 0, 0, 1, 0, 0, 210);
    sof(30);
    chk("frz_exit", phase, 1);

    power_pellet = 1'b1;
    clk1();
    power_pellet = 1'b0;
    chk("fr_phase", phase, 2);
    chk("fr_flag", frightened, 1);
    sof(20);
    push(2'b00, 2'b10, 0, 1, 2, 0, 1, 230);
    collision_pac_ghost = 2'b10;
    repeat (3) clk1();
    collision_pac_ghost = 2'b00;
    clk1();
    push(2'b10, 2'b00, 0, 0, 2, 0, 1, 285);
    push(2'b01, 2'b00, 0, 0, 2, 0, 1, 360);
    sof(159);
    chk("fr_last", phase, 2);
    sof(1);
    chk("fr_end", phase, 1);
    chk("fr_end_flag", frightened, 0);

    power_pellet = 1'b1;
    clk1();
    power_pellet = 1'b0;
    push(2'b10, 2'b00, 0, 0, 2, 0, 1, 435);
    push(2'b01, 2'b00, 0, 0, 2, 0, 1, 510);
    sof(170);
    power_pellet = 1'b1;
    clk1();
    power_pellet = 1'b0;
    push(2'b10, 2'b00, 0, 0, 2, 0, 1, 585);
    push(2'b01, 2'b00, 0, 0, 2, 0, 1, 660);
    push(2'b10, 2'b00, 0, 0, 2, 0, 1, 735);
    sof(10);
    chk("refr_hold", frightened, 1);
    sof(169);
    chk("refr_last", phase, 2);
    sof(1);
    chk("refr_end", phase, 1);

    push(2'b00, 2'b00, 1, 0, 3, 1, 0, 740);
    collision_pac_ghost = 2'b01;
    power_pellet = 1'b1;
    clk1();
    collision_pac_ghost = 2'b00;
    power_pellet = 1'b0;
    clk1();
    chk("prio_phase", phase, 3);
    chk("prio_fright", frightened, 0);
    sof(30);

    resetN = 1'b0;
    #2;
    chk("mid_rst_phase", phase, 0);
    chk("mid_rst_stop", ghost_stop, 1);
    clk1();
    resetN = 1'b1;
    repeat (3) clk1();
    sof(5);
    chk("post_rst_phase", phase, 0);
    chk("post_rst_stop", ghost_stop, 1);

    chk("pending_events", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ghost_mode_scheduler.md
Name: ghost_mode_scheduler

Overview:
Central sequencer for all ghost movers. It generates per-ghost, staggered direction-change pulses and held 2-bit random selectors. It also owns the global game phase (run / frightened / freeze-after-death) and drives the per-ghost stop/reset controls. It sits between the collision logic and the ghost movement modules, and replaces the ad-hoc fivesec/random/stop/reset wiring.

Parameters:
NUM_GHOSTS, 2, number of ghost movers served (1..4)
TURN_PERIOD_FRAMES, 150, frames between turn pulses per ghost (5 s at 30 Hz)
FRIGHT_FRAMES, 180, length of frightened phase in frames
FREEZE_FRAMES, 60, all-stop hold after pac/ghost collision, in frames
LFSR_SEED, 16'hACE1, non-zero reset value of the random LFSR

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-clock pulse per frame
game_start  in  1  level-sensitive; leaves IDLE
power_pellet  in  1  one-clock pulse when pacman eats a pellet
collision_pac_ghost  in  NUM_GHOSTS  per-ghost pac collision, level
turn_pulse  out  NUM_GHOSTS  one-clock "change direction" pulse per ghost
random  out  2*NUM_GHOSTS  per-ghost 2-bit selector, ghost i at [2i+1:2i]
ghost_stop  out  1  freeze all ghosts
ghost_reset  out  NUM_GHOSTS  one-clock pulse; return ghost i to start
frightened  out  1  high during frightened phase
life_lost  out  1  one-clock pulse on fatal collision
ghost_eaten  out  1  one-clock pulse when a frightened ghost is caught
phase  out  2  0=IDLE 1=RUN 2=FRIGHT 3=FREEZE

Behaviour:
- Reset (resetN=0, asynchronous): state IDLE; all pulses 0; ghost_stop=1; frightened=0; random=0; LFSR=LFSR_SEED. Turn counter i = i*(TURN_PERIOD_FRAMES/NUM_GHOSTS), integer division.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every clock in every state except reset.
- IDLE: ghost_stop=1. When game_start=1, go to RUN next clock, pulse ghost_reset for all ghosts for one clock, and reload the turn counters.
- RUN / FRIGHT, turn counters:
  - On startOfFrame, each counter increments.
  - At TURN_PERIOD_FRAMES-1 the counter wraps to 0, and turn_pulse[i] is asserted in the clock after that startOfFrame (latency 1).
  - In the same clock, random[i] loads LFSR[2i+1:2i] and holds until ghost i's next turn pulse.
  - Counters do not advance in IDLE or FREEZE.
- RUN:
  - Any collision_pac_ghost bit set: go to FREEZE, life_lost pulse, freeze counter=0.
  - Else power_pellet: go to FRIGHT, fright counter=0.
  - Collision has priority over a pellet in the same clock.
- FRIGHT:
  - frightened=1.
  - collision_pac_ghost[i]: ghost_reset[i] pulse and one ghost_eaten pulse; state stays FRIGHT. Several ghosts in one clock give several ghost_reset bits but a single ghost_eaten pulse.
  - A collision bit held high produces only one pulse: rising-edge detect per bit.
  - power_pellet restarts the fright counter at 0.
  - Fright counter counts startOfFrame. At FRIGHT_FRAMES-1, return to RUN on the next clock.
- FREEZE:
  - ghost_stop=1; collisions and pellets are ignored.
  - Freeze counter counts startOfFrame. At FREEZE_FRAMES-1, pulse ghost_reset for all ghosts, reload the turn counters, and go to RUN.
- ghost_stop=1 only in IDLE and FREEZE.
- phase is registered and matches the current state.
- Counters are sized $clog2(max frames)+1 and never overflow; FRIGHT_FRAMES=1 ends after one frame.
- resetN asserted mid-phase: immediate return to reset values; no pulses are emitted on release.

Decomposition:
- Package ghost_ctrl_pkg:
  - phase enum (IDLE, RUN, FRIGHT, FREEZE)
  - LFSR tap constant
  - MAX_GHOSTS=4
- Sub-module ghost_turn_timer, instantiated NUM_GHOSTS times. Contains:
  - frame counter with offset load and enable
  - turn_pulse generation
  - random capture register

Test Plan:
- Reset, then game_start=1 → phase 0→1; ghost_reset=2'b11 for one clock; ghost_stop falls to 0.
- RUN, 150 startOfFrame pulses, NUM_GHOSTS=2 → ghost 0 pulses at frame 150; ghost 1 pulses at frame 75 (offset 75, so 75 frames to wrap); each pulse is one clock and random latches fresh LFSR bits.
- RUN, collision_pac_ghost=2'b01 held 10 clocks → one life_lost pulse; phase=3; ghost_stop=1 for 60 frames; then ghost_reset=2'b11 and phase=1.
- RUN, power_pellet, then collision on ghost 1 at frame 20 → frightened=1; ghost_reset=2'b10 and ghost_eaten pulse once; no life_lost; phase back to 1 after 180 frames.
- FRIGHT at frame 170, second power_pellet → frightened stays high until frame 170+180.
- Same-clock collision and power_pellet in RUN → FREEZE, no FRIGHT. resetN pulsed during FREEZE → phase=0, ghost_stop=1, no ghost_reset pulse.
